// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (a - b), LSB first, behind valid/ready handshakes.
// Optional checks are compiled in by defining SERIAL_SUB_ASSERT_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready high
  // BUSY  | one full-subtractor bit-step per cycle, then a final cycle to DONE
  // DONE  | result presented, held until out_ready
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic a0, b0, bit_d, br_next;

  assign a0      = a_q[0];
  assign b0      = b_q[0];
  assign bit_d   = a0 ^ b0 ^ br_q;
  assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  assign in_ready   = rst_n && (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = br_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Counter saturates at WIDTH; the extra cycle here gives the WIDTH+1 latency.
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          diff_d = {bit_d, diff_q[WIDTH-1:1]};
          a_d    = a_q >> 1;
          b_d    = b_q >> 1;
          br_d   = br_next;
          cnt_d  = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_SUB_ASSERT_EN
  logic [WIDTH-1:0] a_cap_q, b_cap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cap_q <= '0;
      b_cap_q <= '0;
    end else if (in_valid && in_ready) begin
      a_cap_q <= a;
      b_cap_q <= b;
    end
  end

  a_result: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> (diff == WIDTH'(a_cap_q - b_cap_q)) && (borrow_out == (a_cap_q < b_cap_q)))
    else $error("a_result");

  a_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> ($stable(diff) && $stable(borrow_out) && $stable(out_valid)))
    else $error("a_stable");

  a_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid))
    else $error("a_excl");

  a_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= CNT_LAST)
    else $error("a_cnt");
`else
`endif

endmodule
